ej1_frame_tx: RTL

//  Transmit side of the ej1 S/I serial link: drives the S (sync/clear) and I (data) lines consumed by ej1b.

---
 rtl/ej1_frame_tx_pkg.sv | 15 +
 rtl/ej1_piso.sv | 28 ++
 rtl/ej1_frame_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/ej1_frame_tx_pkg.sv
// Shared definitions for the ej1 S/I link transmitter.
package ej1_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ej1_piso.sv
// Parallel-in/serial-out shift register; shift direction fixed at elaboration.
module ej1_piso #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             shift,
    output logic             bit_c
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= data_in;
        end else if (shift) begin
            sr_q <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    assign bit_c = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/ej1_frame_tx.sv
// ej1 frame transmitter: S preamble, WIDTH data bits on I, then one gap cycle with done.
module ej1_frame_tx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_CYCLES = 1,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             S,
    output logic             I,
    output logic             done
);

    import ej1_frame_tx_pkg::*;

    localparam int unsigned CNT_W = $clog2(max_u(WIDTH, SYNC_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture_c;
    logic             shift_c;
    logic             bit_c;

    ej1_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .load    (capture_c),
        .shift   (shift_c),
        .bit_c   (bit_c)
    );

    // Next state; the down-counter reloads on every state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        shift_c   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (load) begin
                    capture_c = 1'b1;
                    state_d   = ST_SYNC;
                    cnt_d     = SYNC_LAST;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LAST;
                    shift_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    shift_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line and status flops are loaded from the next state so they track it without decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            S       <= 1'b0;
            I       <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            S       <= (state_d == ST_SYNC);
            I       <= shift_c & bit_c;
            done    <= (state_d == ST_GAP);
            ready   <= (state_d == ST_IDLE) || (state_d == ST_GAP);
        end
    end

endmodule
